// File: rtl/nco_freq_est.sv
// Square-wave frequency estimator: averages EDGES input periods and divides to recover
// the NCO phase increment that would reproduce the measured frequency.
module nco_freq_est #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned EDGES     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sinewave_in,
  output logic [WIDTH-1:0] phase_inc_est,
  output logic             est_valid,
  output logic             timeout,
  output logic             busy
);

  localparam int unsigned EcW = $clog2(EDGES + 1);
  localparam int unsigned ItW = $clog2(WIDTH + 1);

  localparam logic [EcW-1:0]       EdgeLast = EcW'(EDGES - 1);
  localparam logic [ItW-1:0]       ItLast   = ItW'(WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] CntLast  = ~CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH:0]   EdgesRem = (CNT_WIDTH + 1)'(EDGES);

  typedef enum logic [1:0] {StIdle, StMeasure, StDivide} state_e;

  state_e               state_q, state_d;
  logic [2:0]           sync_q, sync_d;
  logic [CNT_WIDTH-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [EcW-1:0]       edge_cnt_q, edge_cnt_d;
  logic [CNT_WIDTH-1:0] div_q, div_d;
  logic [CNT_WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic                 sat_q, sat_d;
  logic [ItW-1:0]       iter_q, iter_d;
  logic [WIDTH-1:0]     phase_q, phase_d;
  logic                 est_valid_q, est_valid_d;
  logic                 timeout_q, timeout_d;

  logic                 edge_det;
  logic [CNT_WIDTH:0]   rem_shift;
  logic [CNT_WIDTH:0]   rem_sub;
  logic                 q_bit;

  always_comb begin
    sync_d      = {sync_q[1:0], sinewave_in};
    edge_det    = sync_q[1] & ~sync_q[2];

    // Remainder stays below the divisor, so its top bit is zero between steps.
    rem_shift   = {rem_q[CNT_WIDTH-1:0], 1'b0};
    q_bit       = rem_q[CNT_WIDTH] | (rem_shift >= {1'b0, div_q});
    rem_sub     = rem_shift - {1'b0, div_q};

    state_d     = state_q;
    cyc_cnt_d   = cyc_cnt_q;
    edge_cnt_d  = edge_cnt_q;
    div_d       = div_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    sat_d       = sat_q;
    iter_d      = iter_q;
    phase_d     = phase_q;
    est_valid_d = 1'b0;
    timeout_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (edge_det) begin
          cyc_cnt_d  = CNT_WIDTH'(1);
          edge_cnt_d = '0;
          state_d    = StMeasure;
        end
      end
      StMeasure: begin
        cyc_cnt_d = cyc_cnt_q + 1'b1;
        if (edge_det) begin
          edge_cnt_d = edge_cnt_q + 1'b1;
        end
        if (edge_det && (edge_cnt_q == EdgeLast)) begin
          div_d   = cyc_cnt_q;
          // The integer part EDGES/D must be zero for Q to fit in WIDTH bits.
          sat_d   = (EdgesRem >= {1'b0, cyc_cnt_q});
          rem_d   = sat_d ? '0 : EdgesRem;
          quo_d   = '0;
          iter_d  = '0;
          state_d = StDivide;
        end else if (cyc_cnt_q == CntLast) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end
      end
      StDivide: begin
        rem_d  = q_bit ? rem_sub : rem_shift;
        quo_d  = {quo_q[WIDTH-2:0], q_bit};
        iter_d = iter_q + 1'b1;
        if (iter_q == ItLast) begin
          phase_d     = sat_q ? '1 : quo_d;
          est_valid_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sync_q      <= '0;
      cyc_cnt_q   <= '0;
      edge_cnt_q  <= '0;
      div_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      sat_q       <= 1'b0;
      iter_q      <= '0;
      phase_q     <= '0;
      est_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      cyc_cnt_q   <= cyc_cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      div_q       <= div_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      sat_q       <= sat_d;
      iter_q      <= iter_d;
      phase_q     <= phase_d;
      est_valid_q <= est_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign phase_inc_est = phase_q;
  assign est_valid     = est_valid_q;
  assign timeout       = timeout_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_nco_freq_est.sv
// Bench for nco_freq_est: two instances (long and short cycle counter) share one input and
// are checked every cycle against an event-level model of the measurement.
module tb_nco_freq_est;

  localparam int W = 32;
  localparam int E = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sinewave_in = 1'b0;
  logic [31:0] est_a, est_b;
  logic        val_a, val_b, to_a, to_b, busy_a, busy_b;

  always #5 clk = ~clk;

  nco_freq_est #(.WIDTH(32), .CNT_WIDTH(32), .EDGES(4)) u_dut_a (
    .clk           (clk),
    .rst_n         (rst_n),
    .sinewave_in   (sinewave_in),
    .phase_inc_est (est_a),
    .est_valid     (val_a),
    .timeout       (to_a),
    .busy          (busy_a)
  );

  nco_freq_est #(.WIDTH(32), .CNT_WIDTH(8), .EDGES(4)) u_dut_b (
    .clk           (clk),
    .rst_n         (rst_n),
    .sinewave_in   (sinewave_in),
    .phase_inc_est (est_b),
    .est_valid     (val_b),
    .timeout       (to_b),
    .busy          (busy_b)
  );

  logic [31:0] d_est [2];
  logic        d_val [2];
  logic        d_to  [2];
  logic        d_bsy [2];
  assign d_est[0] = est_a;  assign d_est[1] = est_b;
  assign d_val[0] = val_a;  assign d_val[1] = val_b;
  assign d_to[0]  = to_a;   assign d_to[1]  = to_b;
  assign d_bsy[0] = busy_a; assign d_bsy[1] = busy_b;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Input as seen by the design: edge detected one cycle after the rising edge is sampled.
  logic x1, x2, x3;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1 <= 1'b0; x2 <= 1'b0; x3 <= 1'b0;
    end else begin
      x1 <= sinewave_in; x2 <= x1; x3 <= x2;
    end
  end

  // Model: 0 idle, 1 measuring, 2 dividing (result due at tend).
  int          mst      [2];
  int          cnt      [2];
  longint      t0       [2];
  longint      tend     [2];
  longint      t1p      [2];
  longint      done_t1  [2];
  longint      to_t0    [2];
  longint      lim      [2];
  logic [31:0] exp_est  [2];
  logic [31:0] pend     [2];
  longint      obs_val  [2];
  longint      obs_to   [2];
  int          to_count [2];
  int          val_count[2];
  longint      cyc = 0;

  initial begin
    lim[0] = 64'hFFFF_FFFF;
    lim[1] = 255;
    for (int i = 0; i < 2; i++) begin
      mst[i] = 0; cnt[i] = 0; t0[i] = 0; tend[i] = 0; t1p[i] = 0; done_t1[i] = 0;
      to_t0[i] = 0; exp_est[i] = '0; pend[i] = '0; obs_val[i] = 0; obs_to[i] = 0;
      to_count[i] = 0; val_count[i] = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        logic        ev, to, bsy, det;
        logic [63:0] q;
        ev  = 1'b0;
        to  = 1'b0;
        det = x2 & ~x3;
        if (!rst_n) begin
          mst[i]     = 0;
          exp_est[i] = '0;
        end else begin
          if (mst[i] == 2 && cyc == tend[i]) begin
            exp_est[i] = pend[i]; ev = 1'b1; mst[i] = 0; done_t1[i] = t1p[i];
          end
          if (mst[i] == 1 && cyc == t0[i] + lim[i]) begin
            to = 1'b1; mst[i] = 0; to_t0[i] = t0[i];
          end
        end
        bsy = (mst[i] != 0);
        if (rst_n && det) begin
          if (mst[i] == 0) begin
            t0[i] = cyc; cnt[i] = 0; mst[i] = 1;
          end else if (mst[i] == 1) begin
            cnt[i]++;
            if (cnt[i] == E) begin
              q = (64'(E) << W) / 64'(cyc - t0[i]);
              pend[i] = (q > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : q[31:0];
              t1p[i]  = cyc;
              tend[i] = cyc + W + 1;
              mst[i]  = 2;
            end
          end
        end
        chk($sformatf("est_valid[%0d]@%0d", i, cyc), 64'(d_val[i]), 64'(ev));
        chk($sformatf("timeout[%0d]@%0d", i, cyc), 64'(d_to[i]), 64'(to));
        chk($sformatf("busy[%0d]@%0d", i, cyc), 64'(d_bsy[i]), 64'(bsy));
        chk($sformatf("phase_inc_est[%0d]@%0d", i, cyc), 64'(d_est[i]), 64'(exp_est[i]));
        if (d_val[i] === 1'b1) begin obs_val[i] = cyc; val_count[i]++; end
        if (d_to[i] === 1'b1) begin obs_to[i] = cyc; to_count[i]++; end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic hold(input logic v, input int n);
    for (int k = 0; k < n; k++) begin
      step();
      sinewave_in = v;
    end
  endtask

  task automatic drive_wave(input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      step();
      sinewave_in = ((k % (hi + lo)) < hi);
    end
  endtask

  task automatic drive_nco(input logic [31:0] inc, input logic use_cos, input int n);
    logic [31:0] acc;
    acc = '0;
    for (int k = 0; k < n; k++) begin
      step();
      acc = acc + inc;
      sinewave_in = use_cos ? ~(acc[31] ^ acc[30]) : acc[31];
    end
  endtask

  initial begin
    int snap_to, snap_val, k;
    bit hit;
    repeat (3) step();
    rst_n = 1'b1;

    // Idle with input low: nothing moves, no timeout.
    hold(1'b0, 1000);
    chk("idle_est_a", 64'(est_a), 64'h0);
    chk("idle_timeouts_b", 64'(to_count[1]), 64'h0);

    // 16-cycle wave: D=64.
    drive_wave(8, 8, 500);
    chk("int_est_a", 64'(est_a), 64'h1000_0000);
    chk("int_est_b", 64'(est_b), 64'h1000_0000);
    chk("int_model_a", 64'(exp_est[0]), 64'h1000_0000);
    chk("int_latency_a", 64'(obs_val[0] - done_t1[0]), 64'd33);

    // Closed loop against a behavioural NCO, both quadrature outputs.
    drive_nco(32'h0400_0000, 1'b0, 1200);
    chk("nco_sin_est_a", 64'(est_a), 64'h0400_0000);
    drive_nco(32'h0400_0000, 1'b1, 1200);
    chk("nco_cos_est_a", 64'(est_a), 64'h0400_0000);
    chk("nco_cos_model_a", 64'(exp_est[0]), 64'h0400_0000);

    // 3-cycle wave: D=12, truncated quotient.
    drive_wave(2, 1, 300);
    chk("trunc_est_a", 64'(est_a), 64'h5555_5555);
    chk("trunc_est_b", 64'(est_b), 64'h5555_5555);

    // Single edge then silence on the 8-bit counter instance.
    hold(1'b0, 300);
    snap_to = to_count[1];
    hold(1'b1, 4);
    hold(1'b0, 300);
    chk("to_pulses_b", 64'(to_count[1] - snap_to), 64'd1);
    chk("to_latency_b", 64'(obs_to[1] - to_t0[1]), 64'd255);
    chk("to_hold_est_b", 64'(est_b), 64'h5555_5555);
    drive_wave(8, 8, 500);
    chk("after_to_est_b", 64'(est_b), 64'h1000_0000);
    chk("after_to_est_a", 64'(est_a), 64'h1000_0000);

    // Reset in the middle of a division.
    hit = 1'b0;
    k = 0;
    for (int n = 0; n < 400 && !hit; n++) begin
      step();
      sinewave_in = ((k % 16) < 8);
      k++;
      if (mst[0] == 2 && cyc >= t1p[0] + 5) hit = 1'b1;
    end
    chk("reached_divide", 64'(hit), 64'h1);
    snap_val = val_count[0];
    rst_n = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      sinewave_in = ((k % 16) < 8);
      k++;
    end
    rst_n = 1'b1;
    for (int n = 0; n < 40; n++) begin
      step();
      sinewave_in = ((k % 16) < 8);
      k++;
    end
    chk("rst_no_valid_a", 64'(val_count[0] - snap_val), 64'd0);
    chk("rst_est_a", 64'(est_a), 64'h0);
    for (int n = 0; n < 500; n++) begin
      step();
      sinewave_in = ((k % 16) < 8);
      k++;
    end
    chk("rst_recover_est_a", 64'(est_a), 64'h1000_0000);
    chk("rst_recover_est_b", 64'(est_b), 64'h1000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
